fmem_reader: RTL and testbench

Sequential reader for the filter-coefficient ROM (fmem). On a `start` pulse it walks ROM addresses 0..M-1 through the ROM's 1-cycle registered read port. It delivers each signed coefficient word on a valid/ready output stream, marking the final word with `m_last`. A 2-entry skid FIFO absorbs ROM read latency, so downstream MAC logic can apply backpressure without losing or repeating words.

---
 rtl/fmem_reader_if.sv | 31 +++
 rtl/fmem_reader.sv | 142 ++++++++++++++
 tb/tb_fmem_reader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmem_reader_if.sv
// Coefficient ROM read port plus the valid/ready coefficient stream of fmem_reader.
// The master side is the reader; the slave side is the ROM and the downstream consumer.
interface fmem_reader_if #(
   parameter int T  = 11,
   parameter int AW = 4
);
   logic [AW-1:0]       rom_addr;
   logic signed [T-1:0] rom_z;
   logic signed [T-1:0] m_data;
   logic                m_valid;
   logic                m_ready;
   logic                m_last;

   modport master (
      output rom_addr,
      input  rom_z,
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  rom_addr,
      output rom_z,
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/fmem_reader.sv
// Streams the M filter coefficients of the fmem ROM on a valid/ready interface,
// with a 2-entry skid FIFO that absorbs the ROM's one-cycle read latency.
module fmem_reader #(
   parameter int M  = 9,
   parameter int T  = 11,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   fmem_reader_if.master   bus,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

   state_t              state_q, state_d;
   logic [AW-1:0]       rom_addr_q, rom_addr_d;
   logic                inflight_q, inflight_d;
   logic                inflight_last_q, inflight_last_d;
   logic [1:0]          fifo_count_q, fifo_count_d;
   logic signed [T-1:0] head_data_q, head_data_d;
   logic signed [T-1:0] tail_data_q, tail_data_d;
   logic                head_last_q, head_last_d;
   logic                tail_last_q, tail_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                pop;
   logic                issue;
   logic [1:0]          kept;

   // rom_addr always presents the next address to read, so the ROM output in the
   // cycle after an issue is exactly the word being captured.
   always_comb begin
      pop   = (fifo_count_q != 2'd0) && bus.m_ready;
      kept  = fifo_count_q - {1'b0, pop};
      issue = (state_q == RUN) && (({1'b0, kept} + {2'b00, inflight_q}) < 3'd2);

      state_d         = state_q;
      rom_addr_d      = rom_addr_q;
      inflight_d      = issue;
      inflight_last_d = issue && (rom_addr_q == LAST_ADDR);
      head_data_d     = head_data_q;
      head_last_d     = head_last_q;
      tail_data_d     = tail_data_q;
      tail_last_d     = tail_last_q;
      busy_d          = busy_q;
      done_d          = 1'b0;

      if (issue) begin
         rom_addr_d = (rom_addr_q == LAST_ADDR) ? '0 : rom_addr_q + AW'(1);
      end

      if (pop && (fifo_count_q == 2'd2)) begin
         head_data_d = tail_data_q;
         head_last_d = tail_last_q;
      end

      // A captured word lands at the head if the FIFO is empty after this pop.
      if (inflight_q) begin
         if (kept == 2'd0) begin
            head_data_d = bus.rom_z;
            head_last_d = inflight_last_q;
         end else begin
            tail_data_d = bus.rom_z;
            tail_last_d = inflight_last_q;
         end
      end

      fifo_count_d = kept + {1'b0, inflight_q};
      if (fifo_count_d == 2'd0) begin
         head_last_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               busy_d     = 1'b1;
               rom_addr_d = '0;
            end
         end
         RUN: begin
            if (issue && (rom_addr_q == LAST_ADDR)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (done_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (pop && head_last_q) begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         rom_addr_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_count_q    <= 2'd0;
         head_data_q     <= '0;
         head_last_q     <= 1'b0;
         tail_data_q     <= '0;
         tail_last_q     <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rom_addr_q      <= rom_addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_count_q    <= fifo_count_d;
         head_data_q     <= head_data_d;
         head_last_q     <= head_last_d;
         tail_data_q     <= tail_data_d;
         tail_last_q     <= tail_last_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.m_data   = head_data_q;
   assign bus.m_valid  = (fifo_count_q != 2'd0);
   assign bus.m_last   = head_last_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_fmem_reader.sv
// Directed testbench for fmem_reader: a registered-ROM model feeds the reader and a
// negedge monitor logs handshakes, done pulses and per-cycle status for the checks.
module tb_fmem_reader;

   logic clk;
   logic reset;
   logic start;
   logic busy;
   logic done;

   fmem_reader_if #(.T(11), .AW(4)) bus ();

   fmem_reader #(.M(9), .T(11), .AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   int expWords [9] = '{21, -8, 11, -21, 1, -19, -30, 15, 20};
   logic signed [10:0] rom [0:15];

   int compareCount;
   int failCount;
   int cyc;
   int t0;
   int rel;

   int hsData [$];
   int hsLast [$];
   int hsCyc  [$];
   int lastCount;
   int lastCyc;
   int doneCount;
   int doneCyc;
   int busyAt  [64];
   int validAt [64];
   int dataAt  [64];
   int addrAt  [64];

   logic prevStall;
   int   prevData;
   int   prevLast;

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter, advanced on every rising edge
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // ROM model: one-cycle registered read port
   always_ff @(posedge clk) begin
      bus.rom_z <= rom[bus.rom_addr];
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r);
      start       = s;
      bus.m_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic clearLog();
      hsData.delete();
      hsLast.delete();
      hsCyc.delete();
      lastCount = 0;
      lastCyc   = -1;
      doneCount = 0;
      doneCyc   = -1;
      for (int i = 0; i < 64; i++) begin
         busyAt[i]  = -1;
         validAt[i] = -1;
         dataAt[i]  = -1;
         addrAt[i]  = -1;
      end
   endtask

   function automatic int orderErrors();
      int errs;
      errs = 0;
      for (int k = 0; k < hsData.size(); k++) begin
         if (hsData[k] != expWords[k % 9]) errs++;
         if (hsLast[k] != ((k % 9) == 8 ? 1 : 0)) errs++;
      end
      return errs;
   endfunction

   // Monitor: samples mid-cycle, away from the active edge
   initial begin
      prevStall = 1'b0;
      prevData  = 0;
      prevLast  = 0;
      forever begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel >= 0 && rel < 64) begin
            busyAt[rel]  = int'(busy);
            validAt[rel] = int'(bus.m_valid);
            dataAt[rel]  = int'(bus.m_data);
            addrAt[rel]  = int'(bus.rom_addr);
         end
         if (bus.m_valid && bus.m_ready) begin
            hsData.push_back(int'(bus.m_data));
            hsLast.push_back(int'(bus.m_last));
            hsCyc.push_back(rel);
            if (bus.m_last) begin
               lastCount++;
               lastCyc = rel;
            end
         end
         if (done) begin
            doneCount++;
            doneCyc = rel;
         end
         checkOutput("fifo_le2", int'(dut.fifo_count_q <= 2'd2), 1);
         if (prevStall && bus.m_valid) begin
            checkOutput("hold_data", int'(bus.m_data), prevData);
            checkOutput("hold_last", int'(bus.m_last), prevLast);
         end
         prevStall = bus.m_valid && !bus.m_ready;
         prevData  = int'(bus.m_data);
         prevLast  = int'(bus.m_last);
      end
   end

   initial begin
      compareCount = 0;
      failCount    = 0;
      t0           = 0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      for (int i = 0; i < 9; i++) rom[i] = 11'(expWords[i]);
      start       = 1'b0;
      bus.m_ready = 1'b0;
      reset       = 1'b0;
      clearLog();

      // Reset values
      #3 reset = 1'b1;
      #2;
      checkOutput("rst_valid", int'(bus.m_valid), 0);
      checkOutput("rst_last",  int'(bus.m_last), 0);
      checkOutput("rst_busy",  int'(busy), 0);
      checkOutput("rst_done",  int'(done), 0);
      checkOutput("rst_data",  int'(bus.m_data), 0);
      checkOutput("rst_addr",  int'(bus.rom_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Free-running stream
      $display("[TB] free-running stream");
      clearLog();
      t0 = cyc;
      applyStimulus(1'b1, 1'b1);
      for (int i = 1; i < 16; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t1_count", hsData.size(), 9);
      for (int k = 0; k < 9 && k < hsData.size(); k++) begin
         checkOutput($sformatf("t1_data%0d", k), hsData[k], expWords[k]);
         checkOutput($sformatf("t1_cyc%0d", k), hsCyc[k], 3 + k);
      end
      checkOutput("t1_last_count", lastCount, 1);
      checkOutput("t1_last_cyc", lastCyc, 11);
      checkOutput("t1_done_count", doneCount, 1);
      checkOutput("t1_done_cyc", doneCyc, 12);
      checkOutput("t1_busy0", busyAt[0], 0);
      checkOutput("t1_busy1", busyAt[1], 1);
      checkOutput("t1_busy12", busyAt[12], 1);
      checkOutput("t1_busy13", busyAt[13], 0);
      checkOutput("t1_valid2", validAt[2], 0);

      // Backpressure for cycles 0..10
      $display("[TB] backpressure");
      clearLog();
      t0 = cyc;
      applyStimulus(1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t2_valid3", validAt[3], 1);
      checkOutput("t2_data3", dataAt[3], 21);
      checkOutput("t2_data10", dataAt[10], 21);
      checkOutput("t2_issue_bound", int'(addrAt[10] <= 2), 1);
      checkOutput("t2_count", hsData.size(), 9);
      checkOutput("t2_order", orderErrors(), 0);
      for (int k = 0; k < 9 && k < hsCyc.size(); k++) begin
         checkOutput($sformatf("t2_cyc%0d", k), hsCyc[k], 11 + k);
      end
      checkOutput("t2_done_count", doneCount, 1);

      // Random backpressure, 20 passes
      $display("[TB] random ready");
      for (int p = 0; p < 20; p++) begin
         clearLog();
         t0 = cyc;
         applyStimulus(1'b1, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 200 && doneCount == 0; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         end
         checkOutput($sformatf("t3_done_p%0d", p), doneCount, 1);
         checkOutput($sformatf("t3_count_p%0d", p), hsData.size(), 9);
         checkOutput($sformatf("t3_order_p%0d", p), orderErrors(), 0);
         checkOutput($sformatf("t3_last_p%0d", p), lastCount, 1);
      end

      // start pulsed in cycles 0, 4 and 8
      $display("[TB] repeated start");
      clearLog();
      t0 = cyc;
      for (int i = 0; i < 25; i++) begin
         applyStimulus((i == 0 || i == 4 || i == 8) ? 1'b1 : 1'b0, 1'b1);
      end
      checkOutput("t4_count", hsData.size(), 9);
      checkOutput("t4_order", orderErrors(), 0);
      checkOutput("t4_done_count", doneCount, 1);
      checkOutput("t4_done_cyc", doneCyc, 12);

      // Reset mid-pass after 3 handshakes
      $display("[TB] reset mid-pass");
      clearLog();
      t0 = cyc;
      applyStimulus(1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t5_hs_before", hsData.size(), 3);
      reset = 1'b1;
      #1;
      checkOutput("t5_valid", int'(bus.m_valid), 0);
      checkOutput("t5_last",  int'(bus.m_last), 0);
      checkOutput("t5_busy",  int'(busy), 0);
      checkOutput("t5_done",  int'(done), 0);
      checkOutput("t5_data",  int'(bus.m_data), 0);
      checkOutput("t5_addr",  int'(bus.rom_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      clearLog();
      t0 = cyc;
      applyStimulus(1'b1, 1'b1);
      for (int i = 1; i < 16; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t5_count", hsData.size(), 9);
      if (hsData.size() > 0) begin
         checkOutput("t5_first_data", hsData[0], 21);
         checkOutput("t5_first_cyc", hsCyc[0], 3);
      end else begin
         checkOutput("t5_first_present", 0, 1);
      end
      checkOutput("t5_order", orderErrors(), 0);

      // Back-to-back passes
      $display("[TB] back-to-back");
      clearLog();
      t0 = cyc;
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 40 && doneCount == 0; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t6_done_seen", doneCount, 1);
      checkOutput("t6_restart_cyc", cyc - t0, 13);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("t6_count", hsData.size(), 18);
      if (hsData.size() > 9) begin
         checkOutput("t6_second_cyc", hsCyc[9], 16);
         checkOutput("t6_second_data", hsData[9], 21);
         checkOutput("t6_second_last", hsLast[9], 0);
      end else begin
         checkOutput("t6_second_present", 0, 1);
      end
      checkOutput("t6_order", orderErrors(), 0);
      checkOutput("t6_done_count", doneCount, 2);

      applyStimulus(1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
